// File: rtl/regfl_pkg.sv
// Shared register-file package: scan sequencer state encoding and the default
// geometry constants used by the register file and its read-out sequencer.
package regfl_pkg;

  localparam int unsigned REGFL_ADDR_W = 3;
  localparam int unsigned REGFL_DATA_W = 64;

  // Read-out sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } regfl_state_e;

endpackage : regfl_pkg

// File: rtl/regfl_word_sel.sv
// Combinational word select: returns the data_width slice of the flat register
// bus q_in at index idx. Indices at or above register_count return zero.
//   idx   in  address_width              word index
//   q_in  in  register_count*data_width  flat register-file contents
//   word  out data_width                 selected word
module regfl_word_sel
  import regfl_pkg::*;
#(
  parameter int unsigned address_width  = REGFL_ADDR_W,
  parameter int unsigned register_count = 2 ** address_width,
  parameter int unsigned data_width     = REGFL_DATA_W
) (
  input  logic [address_width-1:0]             idx,
  input  logic [register_count*data_width-1:0] q_in,
  output logic [data_width-1:0]                word
);

  // One-hot style mux; keeps out-of-range indices from producing X.
  always_comb begin
    word = '0;
    for (int i = 0; i < int'(register_count); i++) begin
      if (idx == address_width'(i)) begin
        word = q_in[i*data_width +: data_width];
      end
    end
  end

endmodule : regfl_word_sel

// File: rtl/regfl_scan.sv
// Register-file read-out sequencer. On start it walks registers 0 to
// register_count-1 of the flat register bus and streams one word per transfer
// on a valid/ready interface, tagged with its address and a last flag.
// Words are not snapshotted: each word samples q_in on the edge it is loaded.
//
// Ports:
//   clk, rst_b  clock; asynchronous active-low reset
//   start       scan request, sampled only while idle
//   q_in        flat register-file contents, word i at [i*data_width +: data_width]
//   out_data    current word            out_addr   index of out_data
//   out_valid   word available          out_ready  consumer accepts the word
//   out_last    out_data is the final word (decoded from registered state)
//   busy        scan in progress (SEND or DONE)
//   done        one-cycle pulse after the final word is accepted
//   chk         running XOR of transferred words      (REGFL_SCAN_CHKSUM_EN)
//   chk_valid   pulses with done                      (REGFL_SCAN_CHKSUM_EN)
//
// Optional feature: define REGFL_SCAN_CHKSUM_EN to add the chk/chk_valid outputs.
module regfl_scan
  import regfl_pkg::*;
#(
  parameter int unsigned address_width  = REGFL_ADDR_W,
  parameter int unsigned register_count = 2 ** address_width,
  parameter int unsigned data_width     = REGFL_DATA_W
) (
  input  logic                                 clk,
  input  logic                                 rst_b,
  input  logic                                 start,
  input  logic [register_count*data_width-1:0] q_in,
  output logic [data_width-1:0]                out_data,
  output logic [address_width-1:0]             out_addr,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
`ifdef REGFL_SCAN_CHKSUM_EN
  output logic [data_width-1:0]                chk,
  output logic                                 chk_valid,
`endif
  output logic                                 busy,
  output logic                                 done
);

  localparam logic [address_width-1:0] LAST_IDX = address_width'(register_count - 1);

  regfl_state_e               state_q, state_d;
  logic [data_width-1:0]      data_q, data_d;
  logic [address_width-1:0]   addr_q, addr_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [address_width-1:0]   sel_idx;
  logic [data_width-1:0]      sel_word;
  logic                       xfer;
  logic                       at_last;

  assign xfer    = valid_q & out_ready;
  assign at_last = (addr_q == LAST_IDX);

  // Word 0 on the start edge, otherwise the word after the one being accepted.
  assign sel_idx = (state_q == IDLE) ? '0 : addr_q + address_width'(1);

  regfl_word_sel #(
    .address_width  (address_width),
    .register_count (register_count),
    .data_width     (data_width)
  ) u_word_sel (
    .idx  (sel_idx),
    .q_in (q_in),
    .word (sel_word)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          data_d  = sel_word;
          addr_d  = '0;
          valid_d = 1'b1;
        end
      end
      SEND: begin
        if (xfer) begin
          if (at_last) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + address_width'(1);
            data_d = sel_word;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign out_valid = valid_q;
  assign out_last  = valid_q & at_last;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef REGFL_SCAN_CHKSUM_EN
  logic [data_width-1:0] chk_q, chk_d;
  logic                  chk_valid_q;

  // Running XOR: cleared on start, folded on every accepted word.
  always_comb begin
    chk_d = chk_q;
    if (state_q == IDLE && start) begin
      chk_d = '0;
    end else if (state_q == SEND && xfer) begin
      chk_d = chk_q ^ data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      chk_q       <= '0;
      chk_valid_q <= 1'b0;
    end else begin
      chk_q       <= chk_d;
      chk_valid_q <= done_d;
    end
  end

  assign chk       = chk_q;
  assign chk_valid = chk_valid_q;
`endif

endmodule : regfl_scan

// File: tb/tb_regfl_scan.sv
// Directed bench for regfl_scan with a 4 x 8-bit register file.
module tb_regfl_scan;

  localparam int unsigned AW = 2;
  localparam int unsigned RC = 4;
  localparam int unsigned DW = 8;
  localparam logic [31:0] Q_INIT = 32'h44332211;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          start;
  logic [31:0]   q_in;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef REGFL_SCAN_CHKSUM_EN
  logic [DW-1:0] chk;
  logic          chk_valid;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfl_scan #(
    .address_width  (AW),
    .register_count (RC),
    .data_width     (DW)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .q_in      (q_in),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
`ifdef REGFL_SCAN_CHKSUM_EN
    .chk       (chk),
    .chk_valid (chk_valid),
`endif
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " data"},  32'(out_data),  32'h0);
    check({tag, " addr"},  32'(out_addr),  32'h0);
    check({tag, " valid"}, 32'(out_valid), 32'h0);
    check({tag, " last"},  32'(out_last),  32'h0);
    check({tag, " busy"},  32'(busy),      32'h0);
    check({tag, " done"},  32'(done),      32'h0);
`ifdef REGFL_SCAN_CHKSUM_EN
    check({tag, " chk"},       32'(chk),       32'h0);
    check({tag, " chk_valid"}, 32'(chk_valid), 32'h0);
`endif
  endtask

  task automatic check_beat(input string tag, input int b, input logic [7:0] d);
    check({tag, " valid"}, 32'(out_valid), 32'h1);
    check({tag, " addr"},  32'(out_addr),  32'(b));
    check({tag, " data"},  32'(out_data),  32'(d));
    check({tag, " last"},  32'(out_last),  (b == 3) ? 32'h1 : 32'h0);
    check({tag, " busy"},  32'(busy),      32'h1);
    check({tag, " done"},  32'(done),      32'h0);
  endtask

  // Full scan with out_ready high; checks each beat, done pulse and idle return.
  task automatic scan_full(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3, input logic [7:0] ck);
    logic [7:0] exp_d [4];
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
`ifdef REGFL_SCAN_CHKSUM_EN
    check({tag, " chk cleared"}, 32'(chk), 32'h0);
`endif
    for (int b = 0; b < 4; b++) begin
      check_beat($sformatf("%s beat%0d", tag, b), b, exp_d[b]);
      @(negedge clk);
    end
    check({tag, " done pulse"},  32'(done),      32'h1);
    check({tag, " done valid"},  32'(out_valid), 32'h0);
    check({tag, " done busy"},   32'(busy),      32'h1);
`ifdef REGFL_SCAN_CHKSUM_EN
    check({tag, " chk_valid"},   32'(chk_valid), 32'h1);
    check({tag, " chk value"},   32'(chk),       32'(ck));
`endif
    @(negedge clk);
    check({tag, " after done"},  32'(done),      32'h0);
    check({tag, " after busy"},  32'(busy),      32'h0);
    check({tag, " after valid"}, 32'(out_valid), 32'h0);
`ifdef REGFL_SCAN_CHKSUM_EN
    check({tag, " chk_valid off"}, 32'(chk_valid), 32'h0);
    check({tag, " chk held"},      32'(chk),       32'(ck));
`endif
  endtask

  initial begin
    rst_b = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    q_in = Q_INIT;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_b = 1'b1;

    // Idle without start: nothing emitted.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d valid", i), 32'(out_valid), 32'h0);
      check($sformatf("idle%0d busy", i),  32'(busy),      32'h0);
    end

    // Back-to-back scan.  11^22^33^44 = 44.
    scan_full("scan1", 8'h11, 8'h22, 8'h33, 8'h44, 8'h44);

    // Backpressure on beat 1, q_in word 2 rewritten, start held mid-scan.
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_beat("bp beat0", 0, 8'h11);
    @(negedge clk);
    check_beat("bp beat1", 1, 8'h22);
    out_ready = 1'b0;
    start = 1'b1;
    q_in[23:16] = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_beat($sformatf("bp stall%0d", i), 1, 8'h22);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_beat("bp beat2", 2, 8'hAA);
    @(negedge clk);
    check_beat("bp beat3", 3, 8'h44);
    @(negedge clk);
    start = 1'b0;
    check("bp done", 32'(done), 32'h1);
`ifdef REGFL_SCAN_CHKSUM_EN
    // 11^22^AA^44 = DD
    check("bp chk", 32'(chk), 32'hDD);
    check("bp chk_valid", 32'(chk_valid), 32'h1);
`endif
    // Start held through the scan must not trigger a second one.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("no requeue%0d valid", i), 32'(out_valid), 32'h0);
      check($sformatf("no requeue%0d busy", i),  32'(busy),      32'h0);
    end
    q_in = Q_INIT;

    // Asynchronous reset during beat 2.
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_beat("rst beat0", 0, 8'h11);
    @(negedge clk);
    @(negedge clk);
    check_beat("rst beat2", 2, 8'h33);
    #1 rst_b = 1'b0;
    #1 check_all_zero("async rst");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("rst hold%0d done", i), 32'(done), 32'h0);
    end
    rst_b = 1'b1;
    @(negedge clk);
    check("post rst done", 32'(done), 32'h0);
    check("post rst busy", 32'(busy), 32'h0);

    scan_full("scan2", 8'h11, 8'h22, 8'h33, 8'h44, 8'h44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_regfl_scan
